etx_serializer: RTL



---
 rtl/etx_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/etx_serializer.sv
// eLink TX serializer: one eMesh packet in, LSB-first framed byte stream out, with a one-packet hold buffer.
// Optional trailing CRC-8 beat when ETX_SERIALIZER_CRC_EN is defined.
//
// state | meaning
// IDLE  | shifter empty, tx_frame low
// SEND  | shifter valid, presenting packet beat idx
// CRC   | packet beats done, presenting CRC-8 beat (ETX_SERIALIZER_CRC_EN only)
module etx_serializer #(
    parameter int AW = 32,
    parameter int PW = 2*AW+40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          etx_access,
    input  logic [PW-1:0] etx_packet,
    output logic          etx_wait,
    input  logic          tx_wait_in,
    output logic          tx_frame,
    output logic [7:0]    tx_data,
    output logic          tx_busy
);

    localparam int NB = PW/8;
    localparam int IW = $clog2(NB+1);

    typedef enum logic [1:0] {IDLE, SEND, CRC} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] shift_pkt, shift_nx;
    logic [PW-1:0] hold_pkt, hold_nx;
    logic          hold_valid, hold_valid_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [7:0]    data_nx;
    logic          consume, accept, last;
`ifdef ETX_SERIALIZER_CRC_EN
    logic [7:0]    crc, crc_nx;

    function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] b);
        logic [7:0] c;
        c = c_in ^ b;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        return c;
    endfunction
`endif

    function automatic logic [7:0] beat_sel(input logic [PW-1:0] pkt, input logic [IW-1:0] i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < NB; k++)
            if (i == IW'(k)) b = pkt[k*8 +: 8];
        return b;
    endfunction

    assign consume  = tx_frame & ~tx_wait_in;
    assign accept   = etx_access & ~hold_valid;
    assign etx_wait = hold_valid;
    assign tx_busy  = tx_frame | hold_valid;

`ifdef ETX_SERIALIZER_CRC_EN
    assign last = consume & (state == CRC);
`else
    assign last = consume & (state == SEND) & (idx == IW'(NB-1));
`endif

    always_comb begin
        state_nx      = state;
        shift_nx      = shift_pkt;
        hold_nx       = hold_pkt;
        hold_valid_nx = hold_valid;
        idx_nx        = idx;
        data_nx       = 8'h00;
`ifdef ETX_SERIALIZER_CRC_EN
        crc_nx        = crc;
`endif

        if (consume && state == SEND) begin
            idx_nx = idx + IW'(1);
`ifdef ETX_SERIALIZER_CRC_EN
            crc_nx = crc8_step(crc, tx_data);
            if (idx == IW'(NB-1)) state_nx = CRC;
`endif
        end

        // End of frame: the hold packet, if any, follows with no gap.
        if (last) begin
            idx_nx = '0;
`ifdef ETX_SERIALIZER_CRC_EN
            crc_nx = 8'h00;
`endif
            if (hold_valid) begin
                shift_nx      = hold_pkt;
                hold_valid_nx = 1'b0;
                state_nx      = SEND;
            end else begin
                state_nx = IDLE;
            end
        end

        if (accept) begin
            if (state == IDLE || last) begin
                shift_nx = etx_packet;
                idx_nx   = '0;
                state_nx = SEND;
            end else begin
                hold_nx       = etx_packet;
                hold_valid_nx = 1'b1;
            end
        end

        case (state_nx)
            SEND:    data_nx = beat_sel(shift_nx, idx_nx);
`ifdef ETX_SERIALIZER_CRC_EN
            CRC:     data_nx = crc_nx;
`endif
            default: data_nx = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shift_pkt  <= '0;
            hold_pkt   <= '0;
            hold_valid <= 1'b0;
            idx        <= '0;
            tx_frame   <= 1'b0;
            tx_data    <= 8'h00;
`ifdef ETX_SERIALIZER_CRC_EN
            crc        <= 8'h00;
`endif
        end else begin
            state      <= state_nx;
            shift_pkt  <= shift_nx;
            hold_pkt   <= hold_nx;
            hold_valid <= hold_valid_nx;
            idx        <= idx_nx;
            tx_frame   <= (state_nx != IDLE);
            tx_data    <= data_nx;
`ifdef ETX_SERIALIZER_CRC_EN
            crc        <= crc_nx;
`endif
        end
    end

endmodule
